// File: rtl/apb_txn_scheduler_if.sv
// Purpose : bundles the scheduler's burst-request, data-return and handler-command signals.
// Latency : n/a (signal bundle only).
// Backpressure: n/a; master = scheduler side, slave = front-ends/handler side.
// Ports   : write/read burst requests+grants, write FIFO head/pop, read beat return,
//           write response, and the single-beat command/completion handshake to the handler.
interface apb_txn_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
);
    logic                  wr_req_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [LEN_WIDTH-1:0]  wr_len_i;
    logic                  wr_gnt_o;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  wdata_valid_i;
    logic                  wdata_rden_o;
    logic                  rd_req_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [LEN_WIDTH-1:0]  rd_len_i;
    logic                  rd_gnt_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rdata_valid_o;
    logic                  rdata_last_o;
    logic                  rdata_err_o;
    logic                  wresp_valid_o;
    logic                  wresp_err_o;
    logic                  wr_trans_o;
    logic                  rd_trans_o;
    logic [ADDR_WIDTH-1:0] trans_addr_o;
    logic [DATA_WIDTH-1:0] trans_data_o;
    logic [3:0]            burst_len_o;
    logic                  trans_done_i;
    logic                  trans_error_i;
    logic [DATA_WIDTH-1:0] read_data_i;

    modport master (
        input  wr_req_i, wr_addr_i, wr_len_i, wdata_i, wdata_valid_i,
        input  rd_req_i, rd_addr_i, rd_len_i,
        input  trans_done_i, trans_error_i, read_data_i,
        output wr_gnt_o, wdata_rden_o, rd_gnt_o,
        output rdata_o, rdata_valid_o, rdata_last_o, rdata_err_o,
        output wresp_valid_o, wresp_err_o,
        output wr_trans_o, rd_trans_o, trans_addr_o, trans_data_o, burst_len_o
    );

    modport slave (
        output wr_req_i, wr_addr_i, wr_len_i, wdata_i, wdata_valid_i,
        output rd_req_i, rd_addr_i, rd_len_i,
        output trans_done_i, trans_error_i, read_data_i,
        input  wr_gnt_o, wdata_rden_o, rd_gnt_o,
        input  rdata_o, rdata_valid_o, rdata_last_o, rdata_err_o,
        input  wresp_valid_o, wresp_err_o,
        input  wr_trans_o, rd_trans_o, trans_addr_o, trans_data_o, burst_len_o
    );
endinterface

// File: rtl/apb_txn_scheduler.sv
// Purpose : round-robin arbiter + burst sequencer feeding single-beat commands to the APB handler.
// Latency : req->grant 1 cycle, grant->command 1 (read) / 2 (write) cycles, done->next command 1/2 cycles.
// Backpressure: write beats stall without limit on an empty FIFO; losing requester waits; handler watchdogged.
// Ports   : clk, rst (sync, active-high); bus = apb_txn_scheduler_if master modport. Interface widths
//           must match this module's ADDR_WIDTH/DATA_WIDTH/LEN_WIDTH.
module apb_txn_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    apb_txn_scheduler_if.master bus
);
    typedef enum logic [2:0] {IDLE, GRANT, WAIT_DATA, ISSUE, WAIT_DONE, RESP} state_t;

    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    state_t                state;
    logic                  prio_wr;
    logic                  is_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic                  err_acc;
    logic [9:0]            wd;

    logic                  wr_gnt_r, rd_gnt_r, wr_trans_r, rd_trans_r;
    logic                  rdata_valid_r, rdata_last_r, rdata_err_r;
    logic                  wresp_valid_r, wresp_err_r;
    logic [DATA_WIDTH-1:0] rdata_r, trans_data_r;
    logic [ADDR_WIDTH-1:0] trans_addr_r;

    // A watchdog expiry stands in for a completion with error and zero data.
    logic                  wd_expired, beat_done, beat_err, last_beat, wr_win;
    logic [DATA_WIDTH-1:0] beat_data;

    assign wd_expired = (wd == WD_LAST);
    assign beat_done  = bus.trans_done_i || wd_expired;
    assign beat_err   = bus.trans_done_i ? bus.trans_error_i : 1'b1;
    assign beat_data  = bus.trans_done_i ? bus.read_data_i : '0;
    assign last_beat  = (beat_cnt == len);
    assign wr_win     = bus.wr_req_i && (!bus.rd_req_i || prio_wr);

    // Command/grant/response outputs are set on the edge entering the state they belong to,
    // so they are registered yet line up with that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            prio_wr       <= 1'b1;
            is_wr         <= 1'b0;
            addr          <= '0;
            len           <= '0;
            beat_cnt      <= '0;
            err_acc       <= 1'b0;
            wd            <= '0;
            wr_gnt_r      <= 1'b0;
            rd_gnt_r      <= 1'b0;
            wr_trans_r    <= 1'b0;
            rd_trans_r    <= 1'b0;
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
            rdata_err_r   <= 1'b0;
            wresp_valid_r <= 1'b0;
            wresp_err_r   <= 1'b0;
            rdata_r       <= '0;
            trans_data_r  <= '0;
            trans_addr_r  <= '0;
        end else begin
            wr_gnt_r      <= 1'b0;
            rd_gnt_r      <= 1'b0;
            wr_trans_r    <= 1'b0;
            rd_trans_r    <= 1'b0;
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
            rdata_err_r   <= 1'b0;
            wresp_valid_r <= 1'b0;
            wresp_err_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_req_i || bus.rd_req_i) begin
                        is_wr    <= wr_win;
                        addr     <= wr_win ? bus.wr_addr_i : bus.rd_addr_i;
                        len      <= wr_win ? bus.wr_len_i : bus.rd_len_i;
                        prio_wr  <= !wr_win;   // priority moves to the side that lost
                        wr_gnt_r <= wr_win;
                        rd_gnt_r <= !wr_win;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    beat_cnt <= '0;
                    err_acc  <= 1'b0;
                    if (is_wr) begin
                        state <= WAIT_DATA;
                    end else begin
                        rd_trans_r   <= 1'b1;
                        trans_addr_r <= addr;
                        state        <= ISSUE;
                    end
                end
                WAIT_DATA: begin
                    if (bus.wdata_valid_i) begin
                        trans_data_r <= bus.wdata_i;
                        trans_addr_r <= addr;
                        wr_trans_r   <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (beat_done) begin
                        err_acc <= err_acc | beat_err;
                        if (!is_wr) begin
                            rdata_valid_r <= 1'b1;
                            rdata_r       <= beat_data;
                            rdata_err_r   <= beat_err;
                            rdata_last_r  <= last_beat;
                        end
                        if (last_beat) begin
                            if (is_wr) begin
                                wresp_valid_r <= 1'b1;
                                wresp_err_r   <= err_acc | beat_err;
                                state         <= RESP;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                            addr     <= addr + ADDR_WIDTH'(4);
                            if (is_wr) begin
                                state <= WAIT_DATA;
                            end else begin
                                rd_trans_r   <= 1'b1;
                                trans_addr_r <= addr + ADDR_WIDTH'(4);
                                state        <= ISSUE;
                            end
                        end
                    end else begin
                        wd <= wd + 10'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wdata_rden_o  = (state == WAIT_DATA) && bus.wdata_valid_i;
    assign bus.wr_gnt_o      = wr_gnt_r;
    assign bus.rd_gnt_o      = rd_gnt_r;
    assign bus.wr_trans_o    = wr_trans_r;
    assign bus.rd_trans_o    = rd_trans_r;
    assign bus.trans_addr_o  = trans_addr_r;
    assign bus.trans_data_o  = trans_data_r;
    assign bus.burst_len_o   = 4'd0;
    assign bus.rdata_o       = rdata_r;
    assign bus.rdata_valid_o = rdata_valid_r;
    assign bus.rdata_last_o  = rdata_last_r;
    assign bus.rdata_err_o   = rdata_err_r;
    assign bus.wresp_valid_o = wresp_valid_r;
    assign bus.wresp_err_o   = wresp_err_r;
endmodule

// File: tb/tb_apb_txn_scheduler.sv
module tb_apb_txn_scheduler;
    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    apb_txn_scheduler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(4)) bus ();

    apb_txn_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(4), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // event logs filled by the monitor
    logic [31:0] tr_addr_q[$];
    logic [31:0] tr_data_q[$];
    logic        tr_wr_q[$];
    int          tr_cyc_q[$];
    logic [31:0] rd_dat_q[$];
    logic        rd_err_q[$];
    logic        rd_last_q[$];
    int          rd_cyc_q[$];
    logic        wresp_err_q[$];
    int          wresp_cyc_q[$];
    logic        gnt_q[$];
    int          gnt_cyc_q[$];
    int          rden_cnt;
    logic [31:0] wfifo[$];
    bit          pop_pending;
    bit          hold_done;
    bit [31:0]   err_mask;
    int          hbeat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: samples outputs mid-cycle and drops each request once granted.
    initial begin
        forever begin
            @(negedge clk);
            pop_pending = bus.wdata_rden_o;
            if (bus.wdata_rden_o) rden_cnt++;
            if (bus.wr_trans_o || bus.rd_trans_o) begin
                tr_addr_q.push_back(bus.trans_addr_o);
                tr_data_q.push_back(bus.trans_data_o);
                tr_wr_q.push_back(bus.wr_trans_o);
                tr_cyc_q.push_back(cyc);
            end
            if (bus.rdata_valid_o) begin
                rd_dat_q.push_back(bus.rdata_o);
                rd_err_q.push_back(bus.rdata_err_o);
                rd_last_q.push_back(bus.rdata_last_o);
                rd_cyc_q.push_back(cyc);
            end
            if (bus.wresp_valid_o) begin
                wresp_err_q.push_back(bus.wresp_err_o);
                wresp_cyc_q.push_back(cyc);
            end
            if (bus.wr_gnt_o) begin
                gnt_q.push_back(1'b1);
                gnt_cyc_q.push_back(cyc);
                bus.wr_req_i = 1'b0;
            end
            if (bus.rd_gnt_o) begin
                gnt_q.push_back(1'b0);
                gnt_cyc_q.push_back(cyc);
                bus.rd_req_i = 1'b0;
            end
        end
    end

    // Write FIFO model: pops at the edge ending a cycle with rden high.
    initial begin
        forever begin
            @(posedge clk);
            if (pop_pending && wfifo.size() > 0) void'(wfifo.pop_front());
            pop_pending = 1'b0;
            #1;
            bus.wdata_valid_i = (wfifo.size() > 0);
            bus.wdata_i       = (wfifo.size() > 0) ? wfifo[0] : 32'h0;
        end
    end

    // Handler model: completes each command 2 cycles after it, data = addr ^ 0x5A5A0000.
    initial begin
        logic [31:0] a;
        forever begin
            if ((bus.wr_trans_o || bus.rd_trans_o) && !hold_done) begin
                a = bus.trans_addr_o;
                repeat (2) @(negedge clk);
                bus.trans_done_i  = 1'b1;
                bus.trans_error_i = err_mask[hbeat];
                bus.read_data_i   = a ^ 32'h5A5A_0000;
                hbeat++;
                @(negedge clk);
                bus.trans_done_i  = 1'b0;
                bus.trans_error_i = 1'b0;
                bus.read_data_i   = 32'h0;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic clear_logs();
        tr_addr_q.delete(); tr_data_q.delete(); tr_wr_q.delete(); tr_cyc_q.delete();
        rd_dat_q.delete(); rd_err_q.delete(); rd_last_q.delete(); rd_cyc_q.delete();
        wresp_err_q.delete(); wresp_cyc_q.delete(); gnt_q.delete(); gnt_cyc_q.delete();
        rden_cnt = 0;
        hbeat    = 0;
        err_mask = 32'h0;
    endtask

    task automatic start_read(input logic [31:0] a, input logic [3:0] l);
        @(negedge clk);
        bus.rd_addr_i = a;
        bus.rd_len_i  = l;
        bus.rd_req_i  = 1'b1;
    endtask

    task automatic start_write(input logic [31:0] a, input logic [3:0] l);
        @(negedge clk);
        bus.wr_addr_i = a;
        bus.wr_len_i  = l;
        bus.wr_req_i  = 1'b1;
    endtask

    task automatic wait_for(input int nrd, input int nwr, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rd_dat_q.size() >= nrd && wresp_err_q.size() >= nwr) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] pulses;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        pulses = {bus.wr_gnt_o, bus.rd_gnt_o, bus.wdata_rden_o, bus.rdata_valid_o, bus.rdata_last_o,
                  bus.rdata_err_o, bus.wresp_valid_o, bus.wresp_err_o, bus.wr_trans_o, bus.rd_trans_o};
        n_checks++; if (pulses !== 10'h0) $display("FAIL reset_pulses: got %b want 0", pulses); else n_pass++;
        n_checks++; if (bus.trans_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.trans_addr_o); else n_pass++;
        n_checks++; if (bus.trans_data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", bus.trans_data_o); else n_pass++;
        n_checks++; if (bus.rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); else n_pass++;
        n_checks++; if (bus.burst_len_o !== 4'h0) $display("FAIL burst_len: got %h want 0", bus.burst_len_o); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_read_burst();
        bit ok;
        clear_logs();
        start_read(32'h0001_F000, 4'd3);
        wait_for(4, 0, 200, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL rd_burst_timeout: got %0d beats want 4", rd_dat_q.size()); else n_pass++;
        n_checks++; if (tr_addr_q.size() !== 4) $display("FAIL rd_trans_count: got %0d want 4", tr_addr_q.size()); else n_pass++;
        n_checks++; if (rd_dat_q.size() !== 4) $display("FAIL rd_beat_count: got %0d want 4", rd_dat_q.size()); else n_pass++;
        if (tr_addr_q.size() == 4 && rd_dat_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] ea;
                ea = 32'h0001_F000 + 32'(4 * i);
                n_checks++; if (tr_addr_q[i] !== ea) $display("FAIL rd_addr[%0d]: got %h want %h", i, tr_addr_q[i], ea); else n_pass++;
                n_checks++; if (tr_wr_q[i] !== 1'b0) $display("FAIL rd_dir[%0d]: got %b want 0", i, tr_wr_q[i]); else n_pass++;
                n_checks++; if (rd_dat_q[i] !== (ea ^ 32'h5A5A_0000)) $display("FAIL rd_data[%0d]: got %h want %h", i, rd_dat_q[i], ea ^ 32'h5A5A_0000); else n_pass++;
                n_checks++; if (rd_last_q[i] !== (i == 3)) $display("FAIL rd_last[%0d]: got %b want %b", i, rd_last_q[i], (i == 3)); else n_pass++;
                n_checks++; if (rd_err_q[i] !== 1'b0) $display("FAIL rd_err[%0d]: got %b want 0", i, rd_err_q[i]); else n_pass++;
                n_checks++; if (rd_cyc_q[i] !== tr_cyc_q[i] + 3) $display("FAIL rd_valid_lat[%0d]: got %0d want %0d", i, rd_cyc_q[i] - tr_cyc_q[i], 3); else n_pass++;
                if (i < 3) begin
                    n_checks++; if (tr_cyc_q[i+1] !== rd_cyc_q[i]) $display("FAIL rd_next_issue[%0d]: got cyc %0d want %0d", i, tr_cyc_q[i+1], rd_cyc_q[i]); else n_pass++;
                end
            end
        end
        n_checks++; if (gnt_q.size() !== 1) $display("FAIL rd_gnt_count: got %0d want 1", gnt_q.size()); else n_pass++;
        if (gnt_q.size() == 1 && tr_cyc_q.size() > 0) begin
            n_checks++; if (tr_cyc_q[0] - gnt_cyc_q[0] !== 1) $display("FAIL rd_gnt_to_issue: got %0d want 1", tr_cyc_q[0] - gnt_cyc_q[0]); else n_pass++;
        end
    endtask

    task automatic test_write_burst();
        bit ok;
        clear_logs();
        wfifo.push_back(32'hA5A5_0001);
        wfifo.push_back(32'hA5A5_0002);
        start_write(32'h0000_2000, 4'd1);
        wait_for(0, 1, 200, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL wr_burst_timeout: got %0d resp want 1", wresp_err_q.size()); else n_pass++;
        n_checks++; if (rden_cnt !== 2) $display("FAIL wr_rden_count: got %0d want 2", rden_cnt); else n_pass++;
        n_checks++; if (wresp_err_q.size() !== 1) $display("FAIL wr_resp_count: got %0d want 1", wresp_err_q.size()); else n_pass++;
        n_checks++; if (tr_addr_q.size() !== 2) $display("FAIL wr_trans_count: got %0d want 2", tr_addr_q.size()); else n_pass++;
        if (tr_addr_q.size() == 2 && wresp_err_q.size() == 1) begin
            n_checks++; if (tr_data_q[0] !== 32'hA5A5_0001) $display("FAIL wr_data0: got %h want a5a50001", tr_data_q[0]); else n_pass++;
            n_checks++; if (tr_data_q[1] !== 32'hA5A5_0002) $display("FAIL wr_data1: got %h want a5a50002", tr_data_q[1]); else n_pass++;
            n_checks++; if (tr_addr_q[1] !== 32'h0000_2004) $display("FAIL wr_addr1: got %h want 00002004", tr_addr_q[1]); else n_pass++;
            n_checks++; if (tr_wr_q[0] !== 1'b1) $display("FAIL wr_dir: got %b want 1", tr_wr_q[0]); else n_pass++;
            n_checks++; if (wresp_err_q[0] !== 1'b0) $display("FAIL wr_resp_err: got %b want 0", wresp_err_q[0]); else n_pass++;
            n_checks++; if (tr_cyc_q[0] - gnt_cyc_q[0] !== 2) $display("FAIL wr_gnt_to_issue: got %0d want 2", tr_cyc_q[0] - gnt_cyc_q[0]); else n_pass++;
            n_checks++; if (tr_cyc_q[1] - tr_cyc_q[0] !== 4) $display("FAIL wr_beat_spacing: got %0d want 4", tr_cyc_q[1] - tr_cyc_q[0]); else n_pass++;
            n_checks++; if (wresp_cyc_q[0] - tr_cyc_q[1] !== 3) $display("FAIL wr_resp_lat: got %0d want 3", wresp_cyc_q[0] - tr_cyc_q[1]); else n_pass++;
        end
    endtask

    task automatic test_arbitration();
        bit ok;
        apply_reset();
        clear_logs();
        wfifo.push_back(32'h1111_0000);
        @(negedge clk);
        bus.wr_addr_i = 32'h100; bus.wr_len_i = 4'd0; bus.wr_req_i = 1'b1;
        bus.rd_addr_i = 32'h200; bus.rd_len_i = 4'd0; bus.rd_req_i = 1'b1;
        wait_for(1, 1, 200, ok);
        n_checks++; if (gnt_q.size() !== 2) $display("FAIL arb1_gnt_count: got %0d want 2", gnt_q.size()); else n_pass++;
        if (gnt_q.size() == 2 && tr_addr_q.size() == 2) begin
            n_checks++; if (gnt_q[0] !== 1'b1) $display("FAIL arb1_first: got %b want 1 (write)", gnt_q[0]); else n_pass++;
            n_checks++; if (gnt_q[1] !== 1'b0) $display("FAIL arb1_second: got %b want 0 (read)", gnt_q[1]); else n_pass++;
            n_checks++; if (tr_addr_q[1] !== 32'h200) $display("FAIL arb1_rd_addr: got %h want 200", tr_addr_q[1]); else n_pass++;
        end
        clear_logs();
        wfifo.push_back(32'h2222_0000);
        start_write(32'h300, 4'd0);
        wait_for(0, 1, 200, ok);
        clear_logs();
        wfifo.push_back(32'h3333_0000);
        @(negedge clk);
        bus.wr_addr_i = 32'h400; bus.wr_len_i = 4'd0; bus.wr_req_i = 1'b1;
        bus.rd_addr_i = 32'h500; bus.rd_len_i = 4'd0; bus.rd_req_i = 1'b1;
        wait_for(1, 1, 200, ok);
        n_checks++; if (gnt_q.size() !== 2) $display("FAIL arb2_gnt_count: got %0d want 2", gnt_q.size()); else n_pass++;
        if (gnt_q.size() == 2) begin
            n_checks++; if (gnt_q[0] !== 1'b0) $display("FAIL arb2_first: got %b want 0 (read)", gnt_q[0]); else n_pass++;
            n_checks++; if (gnt_q[1] !== 1'b1) $display("FAIL arb2_second: got %b want 1 (write)", gnt_q[1]); else n_pass++;
        end
    endtask

    task automatic test_errors();
        bit ok;
        clear_logs();
        err_mask = 32'b010;
        wfifo.push_back(32'hE0); wfifo.push_back(32'hE1); wfifo.push_back(32'hE2);
        start_write(32'h0000_5000, 4'd2);
        wait_for(0, 1, 200, ok);
        n_checks++; if (wresp_err_q.size() !== 1) $display("FAIL errw_resp_count: got %0d want 1", wresp_err_q.size()); else n_pass++;
        if (wresp_err_q.size() == 1) begin
            n_checks++; if (wresp_err_q[0] !== 1'b1) $display("FAIL errw_resp_err: got %b want 1", wresp_err_q[0]); else n_pass++;
        end
        clear_logs();
        wfifo.push_back(32'hE3);
        start_write(32'h0000_6000, 4'd0);
        wait_for(0, 1, 200, ok);
        n_checks++; if (wresp_err_q.size() !== 1) $display("FAIL cleanw_resp_count: got %0d want 1", wresp_err_q.size()); else n_pass++;
        if (wresp_err_q.size() == 1) begin
            n_checks++; if (wresp_err_q[0] !== 1'b0) $display("FAIL cleanw_resp_err: got %b want 0", wresp_err_q[0]); else n_pass++;
        end
        clear_logs();
        err_mask = 32'b001;
        start_read(32'h0000_7000, 4'd2);
        wait_for(3, 0, 200, ok);
        n_checks++; if (rd_err_q.size() !== 3) $display("FAIL errr_beat_count: got %0d want 3", rd_err_q.size()); else n_pass++;
        if (rd_err_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (rd_err_q[i] !== (i == 0)) $display("FAIL errr_err[%0d]: got %b want %b", i, rd_err_q[i], (i == 0)); else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        hold_done = 1'b1;
        start_read(32'h0000_0800, 4'd0);
        wait_for(1, 0, 100, ok);
        n_checks++; if (rd_dat_q.size() !== 1) $display("FAIL to_beat_count: got %0d want 1", rd_dat_q.size()); else n_pass++;
        if (rd_dat_q.size() == 1 && tr_cyc_q.size() == 1) begin
            n_checks++; if (rd_err_q[0] !== 1'b1) $display("FAIL to_err: got %b want 1", rd_err_q[0]); else n_pass++;
            n_checks++; if (rd_dat_q[0] !== 32'h0) $display("FAIL to_data: got %h want 0", rd_dat_q[0]); else n_pass++;
            n_checks++; if (rd_last_q[0] !== 1'b1) $display("FAIL to_last: got %b want 1", rd_last_q[0]); else n_pass++;
            n_checks++; if (rd_cyc_q[0] - tr_cyc_q[0] !== 17) $display("FAIL to_latency: got %0d want 17", rd_cyc_q[0] - tr_cyc_q[0]); else n_pass++;
        end
        @(negedge clk);
        bus.trans_done_i = 1'b1;
        bus.read_data_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.trans_done_i = 1'b0;
        bus.read_data_i  = 32'h0;
        repeat (5) @(negedge clk);
        n_checks++; if (rd_dat_q.size() !== 1) $display("FAIL to_late_done: got %0d beats want 1", rd_dat_q.size()); else n_pass++;
        hold_done = 1'b0;
    endtask

    task automatic test_reset_midburst();
        logic [9:0] pulses;
        bit seen;
        clear_logs();
        hold_done = 1'b1;
        for (int i = 0; i < 4; i++) wfifo.push_back(32'hB000_0000 + 32'(i));
        start_write(32'h0000_0900, 4'd3);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tr_addr_q.size() >= 1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL rstm_first_beat: got %0d cmds want 1", tr_addr_q.size()); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulses = {bus.wr_gnt_o, bus.rd_gnt_o, bus.wdata_rden_o, bus.rdata_valid_o, bus.rdata_last_o,
                  bus.rdata_err_o, bus.wresp_valid_o, bus.wresp_err_o, bus.wr_trans_o, bus.rd_trans_o};
        n_checks++; if (pulses !== 10'h0) $display("FAIL rstm_pulses: got %b want 0", pulses); else n_pass++;
        n_checks++; if (bus.trans_addr_o !== 32'h0) $display("FAIL rstm_addr: got %h want 0", bus.trans_addr_o); else n_pass++;
        n_checks++; if (bus.trans_data_o !== 32'h0) $display("FAIL rstm_data: got %h want 0", bus.trans_data_o); else n_pass++;
        rst = 1'b0;
        hold_done = 1'b0;
        wfifo.delete();
        repeat (20) @(negedge clk);
        n_checks++; if (wresp_err_q.size() !== 0) $display("FAIL rstm_no_resp: got %0d want 0", wresp_err_q.size()); else n_pass++;
        n_checks++; if (tr_addr_q.size() !== 1) $display("FAIL rstm_no_more_cmds: got %0d want 1", tr_addr_q.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs();
        start_read(32'hFFFF_FFFC, 4'd1);
        wait_for(2, 0, 200, ok);
        n_checks++; if (tr_addr_q.size() !== 2) $display("FAIL wrap_count: got %0d want 2", tr_addr_q.size()); else n_pass++;
        if (tr_addr_q.size() == 2) begin
            n_checks++; if (tr_addr_q[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", tr_addr_q[0]); else n_pass++;
            n_checks++; if (tr_addr_q[1] !== 32'h0000_0000) $display("FAIL wrap_addr1: got %h want 00000000", tr_addr_q[1]); else n_pass++;
        end
    endtask

    task automatic test_max_len();
        bit ok;
        int nlast;
        clear_logs();
        start_read(32'h0000_1000, 4'hF);
        wait_for(16, 0, 2000, ok);
        n_checks++; if (rd_dat_q.size() !== 16) $display("FAIL max_beats: got %0d want 16", rd_dat_q.size()); else n_pass++;
        if (rd_dat_q.size() == 16 && tr_addr_q.size() == 16) begin
            nlast = 0;
            foreach (rd_last_q[i]) if (rd_last_q[i] === 1'b1) nlast++;
            n_checks++; if (nlast !== 1) $display("FAIL max_last_count: got %0d want 1", nlast); else n_pass++;
            n_checks++; if (rd_last_q[15] !== 1'b1) $display("FAIL max_last_pos: got %b want 1", rd_last_q[15]); else n_pass++;
            n_checks++; if (tr_addr_q[15] !== 32'h0000_103C) $display("FAIL max_addr15: got %h want 0000103c", tr_addr_q[15]); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        hold_done = 1'b0;
        pop_pending = 1'b0;
        err_mask = 32'h0;
        hbeat    = 0;
        rden_cnt = 0;
        bus.wr_req_i = 1'b0; bus.wr_addr_i = 32'h0; bus.wr_len_i = 4'h0;
        bus.rd_req_i = 1'b0; bus.rd_addr_i = 32'h0; bus.rd_len_i = 4'h0;
        bus.wdata_i = 32'h0; bus.wdata_valid_i = 1'b0;
        bus.trans_done_i = 1'b0; bus.trans_error_i = 1'b0; bus.read_data_i = 32'h0;

        test_reset();
        test_read_burst();
        test_write_burst();
        test_arbitration();
        test_errors();
        test_timeout();
        test_reset_midburst();
        test_wrap();
        test_max_len();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
